// File: rtl/contador_param.sv
// Parametrised up/down/step counter with parallel load, cascade carry-in,
// optional saturation and terminal-count compare.
module contador_param #(
    parameter int WIDTH    = 32,
    parameter int DW       = 4,
    parameter int STEP     = 3,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cin,
    input  logic [1:0]       mode,
    input  logic [DW-1:0]    D,
    input  logic [WIDTH-1:0] tc_val,
    output logic             load,
    output logic             rco,
    output logic             tc,
    output logic [WIDTH-1:0] Q
);

    localparam logic [WIDTH-1:0] MAX_W  = '1;
    localparam logic [WIDTH-1:0] ZERO_W = '0;
    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam bit               SAT    = (SATURATE != 0);

    localparam logic [1:0] M_UP   = 2'b00;
    localparam logic [1:0] M_DN   = 2'b01;
    localparam logic [1:0] M_STEP = 2'b10;
    localparam logic [1:0] M_LOAD = 2'b11;

    logic [WIDTH-1:0] q_next;
    logic             load_next;
    logic             rco_next;
    logic [WIDTH-1:0] d_ext;

    // D high bits beyond DW are zero-filled so nothing undefined reaches Q.
    assign d_ext = WIDTH'(D);

    // Next-state selection; crossing a boundary raises rco, an exact
    // landing on zero in step mode does not.
    always_comb begin
        q_next    = Q;
        load_next = 1'b0;
        rco_next  = 1'b0;
        if (enable) begin
            if (mode == M_LOAD) begin
                q_next    = d_ext;
                load_next = 1'b1;
            end else if (cin) begin
                case (mode)
                    M_UP: begin
                        if (Q == MAX_W) begin
                            rco_next = 1'b1;
                            q_next   = SAT ? MAX_W : ZERO_W;
                        end else begin
                            q_next = Q + ONE_W;
                        end
                    end
                    M_DN: begin
                        if (Q == ZERO_W) begin
                            rco_next = 1'b1;
                            q_next   = SAT ? ZERO_W : MAX_W;
                        end else begin
                            q_next = Q - ONE_W;
                        end
                    end
                    M_STEP: begin
                        if (Q < STEP_W) begin
                            rco_next = 1'b1;
                            q_next   = SAT ? ZERO_W : (Q - STEP_W);
                        end else begin
                            q_next = Q - STEP_W;
                        end
                    end
                    default: begin
                        q_next = Q;
                    end
                endcase
            end
        end
    end

    // Registered outputs; reset clears everything without waiting for clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Q    <= '0;
            load <= 1'b0;
            rco  <= 1'b0;
        end else begin
            Q    <= q_next;
            load <= load_next;
            rco  <= rco_next;
        end
    end

    assign tc = (Q == tc_val);

endmodule

// File: tb/tb_contador_param.sv
// Self-checking bench for contador_param: arithmetic reference model for
// three standalone instances plus a cycle-count scoreboard for a cascade.
module tb_contador_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        ci;
    logic [1:0]  md;
    logic [15:0] d;
    logic [31:0] tcv;
    logic        c_en;

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A: 8-bit wrap, B: 8-bit saturate, C: 32-bit with 16-bit load
    logic       ld_a, rc_a, tc_a;
    logic [7:0] q_a;
    logic       ld_b, rc_b, tc_b;
    logic [7:0] q_b;
    logic        ld_c, rc_c, tc_c;
    logic [31:0] q_c;

    contador_param #(.WIDTH(8), .DW(4), .STEP(3), .SATURATE(0)) u_a (
        .clk(clk), .reset(reset), .enable(en), .cin(ci), .mode(md),
        .D(d[3:0]), .tc_val(tcv[7:0]),
        .load(ld_a), .rco(rc_a), .tc(tc_a), .Q(q_a)
    );

    contador_param #(.WIDTH(8), .DW(4), .STEP(3), .SATURATE(1)) u_b (
        .clk(clk), .reset(reset), .enable(en), .cin(ci), .mode(md),
        .D(d[3:0]), .tc_val(tcv[7:0]),
        .load(ld_b), .rco(rc_b), .tc(tc_b), .Q(q_b)
    );

    contador_param #(.WIDTH(32), .DW(16), .STEP(3), .SATURATE(0)) u_c (
        .clk(clk), .reset(reset), .enable(en), .cin(ci), .mode(md),
        .D(d), .tc_val(tcv),
        .load(ld_c), .rco(rc_c), .tc(tc_c), .Q(q_c)
    );

    // Cascade of two 4-bit stages
    logic       ld_l, rc_l, tc_l;
    logic [3:0] q_l;
    logic       ld_u, rc_u, tc_u;
    logic [3:0] q_u;

    contador_param #(.WIDTH(4), .DW(4), .STEP(1), .SATURATE(0)) u_lo (
        .clk(clk), .reset(reset), .enable(c_en), .cin(1'b1), .mode(2'b00),
        .D(4'h0), .tc_val(4'hF),
        .load(ld_l), .rco(rc_l), .tc(tc_l), .Q(q_l)
    );

    contador_param #(.WIDTH(4), .DW(4), .STEP(1), .SATURATE(0)) u_hi (
        .clk(clk), .reset(reset), .enable(c_en), .cin(rc_l), .mode(2'b00),
        .D(4'h0), .tc_val(4'h5),
        .load(ld_u), .rco(rc_u), .tc(tc_u), .Q(q_u)
    );

    // Reference rule: compute the ideal result in signed 64-bit arithmetic
    // and classify it as in range, above max, or below zero.
    function automatic longint nxt(input longint q, input int w,
                                   input int step, input bit sat,
                                   input logic e, input logic c,
                                   input logic [1:0] m, input longint dv,
                                   output bit ldo, output bit rco_o);
        longint mx;
        longint t;
        mx    = (longint'(1) << w) - 1;
        ldo   = 1'b0;
        rco_o = 1'b0;
        if (!e) return q;
        if (m == 2'b11) begin
            ldo = 1'b1;
            return dv;
        end
        if (!c) return q;
        if (m == 2'b00) t = q + 1;
        else if (m == 2'b01) t = q - 1;
        else t = q - step;
        if (t > mx) begin
            rco_o = 1'b1;
            return sat ? mx : 0;
        end
        if (t < 0) begin
            rco_o = 1'b1;
            return sat ? 0 : t + mx + 1;
        end
        return t;
    endfunction

    longint ma, mb, mc, na, nb, nc;
    bit     mla, mra, mlb, mrb, mlc, mrc;
    bit     nla, nra, nlb, nrb, nlc, nrc;

    always_comb begin
        na = 0; nb = 0; nc = 0;
        nla = 0; nra = 0; nlb = 0; nrb = 0; nlc = 0; nrc = 0;
        na = nxt(ma, 8, 3, 1'b0, en, ci, md, longint'(d[3:0]), nla, nra);
        nb = nxt(mb, 8, 3, 1'b1, en, ci, md, longint'(d[3:0]), nlb, nrb);
        nc = nxt(mc, 32, 3, 1'b0, en, ci, md, longint'(d), nlc, nrc);
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma <= 0; mb <= 0; mc <= 0;
            mla <= 0; mra <= 0; mlb <= 0; mrb <= 0; mlc <= 0; mrc <= 0;
        end else begin
            ma <= na; mb <= nb; mc <= nc;
            mla <= nla; mra <= nra;
            mlb <= nlb; mrb <= nrb;
            mlc <= nlc; mrc <= nrc;
        end
    end

    // Cascade scoreboard: k counted cycles; upper stage lags one cycle
    // behind each lower wrap.
    int k;
    always @(posedge clk or negedge reset) begin
        if (!reset) k <= 0;
        else if (c_en) k <= k + 1;
    end

    bit tc_seen = 1'b0;

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        longint el, eu;
        el = k % 16;
        eu = (k == 0) ? 0 : ((k - 1) / 16) % 16;
        chk("a_q", q_a, ma);
        chk("a_load", ld_a, mla);
        chk("a_rco", rc_a, mra);
        chk("a_tc", tc_a, ma == tcv[7:0]);
        chk("b_q", q_b, mb);
        chk("b_load", ld_b, mlb);
        chk("b_rco", rc_b, mrb);
        chk("b_tc", tc_b, mb == tcv[7:0]);
        chk("c_q", q_c, mc);
        chk("c_load", ld_c, mlc);
        chk("c_rco", rc_c, mrc);
        chk("c_tc", tc_c, mc == longint'(tcv));
        chk("cas_lo", q_l, el);
        chk("cas_hi", q_u, eu);
        chk("cas_rco", rc_l, (k > 0) && (k % 16 == 0));
        chk("cas_tc", tc_u, eu == 5);
        chk("cas_load", ld_l | ld_u, 0);
        if (tc_u) tc_seen <= 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; ci = 1'b1; md = 2'b00;
        d = '0; tcv = '0; c_en = 1'b0;
        step();
        step();
        chk("rst_q", q_a, 0);
        chk("rst_tc", tc_a, 1);
        reset = 1'b1;
        tcv = 32'h0000_00AA;

        // load 0x1234, then async reset mid-cycle
        en = 1'b1; md = 2'b11; d = 16'h1234;
        step();
        chk("ld_c_q", q_c, 32'h1234);
        chk("ld_a_q", q_a, 8'h04);
        chk("ld_flag", ld_c, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_q", q_c, 0);
        chk("arst_load", ld_c, 0);
        chk("arst_rco", rc_c, 0);
        reset = 1'b1;
        md = 2'b00;
        step();
        chk("rel_q", q_c, 1);

        // wrap up from 0xFF
        md = 2'b11; d = 16'h000F;
        step();
        md = 2'b00;
        repeat (240) step();
        chk("pre_wrap", q_a, 8'hFF);
        step();
        chk("wrap_q", q_a, 8'h00);
        chk("wrap_rco", rc_a, 1);
        chk("sat1_q", q_b, 8'hFF);
        chk("sat1_rco", rc_b, 1);
        step();
        chk("wrap2_q", q_a, 8'h01);
        chk("wrap2_rco", rc_a, 0);
        chk("sat2_rco", rc_b, 1);
        step();
        chk("sat3_q", q_b, 8'hFF);
        chk("sat3_rco", rc_b, 1);

        // down by STEP
        md = 2'b11; d = 16'h0003;
        step();
        md = 2'b10;
        step();
        chk("st_exact_q", q_a, 8'h00);
        chk("st_exact_rco", rc_a, 0);
        step();
        chk("st_wrap_q", q_a, 8'hFD);
        chk("st_wrap_rco", rc_a, 1);
        chk("st_sat_q", q_b, 8'h00);
        chk("st_sat_rco", rc_b, 1);
        md = 2'b11; d = 16'h0001;
        step();
        md = 2'b10;
        step();
        chk("st1_q", q_a, 8'hFE);
        chk("st1_rco", rc_a, 1);
        chk("st1_sat_q", q_b, 8'h00);

        // mode 01 at zero
        md = 2'b11; d = 16'h0000;
        step();
        md = 2'b01;
        step();
        chk("dn_sat_q", q_b, 8'h00);
        chk("dn_sat_rco", rc_b, 1);
        chk("dn_wrap_q", q_a, 8'hFF);

        // load and hold
        md = 2'b11; d = 16'h000A; tcv = 32'h0000_000A;
        step();
        chk("lh_q", q_a, 8'h0A);
        chk("lh_load", ld_a, 1);
        chk("lh_tc", tc_a, 1);
        en = 1'b0; md = 2'b00;
        repeat (5) step();
        chk("hold_q", q_a, 8'h0A);
        chk("hold_load", ld_a, 0);
        en = 1'b1; ci = 1'b0;
        step();
        chk("cin0_q", q_a, 8'h0A);
        chk("cin0_rco", rc_a, 0);
        ci = 1'b1;

        // cascade from reset
        en = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        c_en = 1'b1;
        repeat (300) step();
        c_en = 1'b0;
        chk("cas_lo_end", q_l, 4'hC);
        chk("cas_hi_end", q_u, 4'h2);
        chk("cas_tc_seen", tc_seen, 1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
